// File: rtl/sb_arbiter_pkg.sv
// Shared types and constants for the system-bus arbiter.
`timescale 1ns/1ps
package sb_arbiter_pkg;

    localparam int BYTE_SEL_W = 4;
    localparam logic [BYTE_SEL_W-1:0] SB_WORD = 4'hF;

    localparam logic HOLD    = 1'b1;
    localparam logic NO_HOLD = 1'b0;

    localparam int SB_STATE_W = 2;

    typedef enum logic [SB_STATE_W-1:0] {
        SB_IDLE   = 2'd0,
        SB_BUS_EX = 2'd1,
        SB_BUS_IF = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_arbiter_watchdog.sv
// Per-transfer timeout counter: armed by start, disarmed by ack or by its own expiry.
`timescale 1ns/1ps
module sb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expire
);

    // The counter holds completed wait cycles, so the limit cycle is seen at TIMEOUT-1.
    localparam logic [7:0] LIMIT = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    logic       r_busy;
    logic [7:0] r_cnt;
    logic       w_expire;

    assign w_expire = (TIMEOUT != 0) && r_busy && !ack && (r_cnt == LIMIT);
    assign expire   = w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= 8'd0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= 8'd0;
        end else if (r_busy) begin
            if (ack || w_expire) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sb_arbiter.sv
// Arbitrates the single system-bus port between execute-stage data accesses and instruction fetch.
`timescale 1ns/1ps
module sb_arbiter
    import sb_arbiter_pkg::*;
#(
    parameter int MAX_EX_BURST = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_req_i,
    input  logic                  ex_we_i,
    input  logic [31:0]           ex_addr_i,
    input  logic [31:0]           ex_wdata_i,
    input  logic [BYTE_SEL_W-1:0] ex_byte_sel_i,
    output logic                  ex_ack_o,
    output logic                  ex_err_o,
    output logic [31:0]           ex_rdata_o,
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    output logic                  if_ack_o,
    output logic                  if_err_o,
    output logic [31:0]           if_rdata_o,
    output logic                  sb_req_o,
    output logic                  sb_we_o,
    output logic [31:0]           sb_addr_o,
    output logic [31:0]           sb_wdata_o,
    output logic [BYTE_SEL_W-1:0] sb_byte_sel_o,
    input  logic                  sb_ack_i,
    input  logic [31:0]           sb_rdata_i,
    output logic                  hold_o
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_EX_BURST);

    sb_state_t             r_state;
    sb_state_t             w_next;
    logic [3:0]            r_streak;
    logic                  r_sb_we;
    logic [31:0]           r_sb_addr;
    logic [31:0]           r_sb_wdata;
    logic [BYTE_SEL_W-1:0] r_sb_byte_sel;
    logic                  w_grant_ex;
    logic                  w_grant_if;
    logic                  w_expire;
    logic                  w_ex_ack;
    logic                  w_ex_err;
    logic                  w_if_ack;
    logic                  w_if_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant_ex = 1'b0;
        w_grant_if = 1'b0;
        w_ex_ack   = 1'b0;
        w_ex_err   = 1'b0;
        w_if_ack   = 1'b0;
        w_if_err   = 1'b0;
        case (r_state)
            SB_IDLE: begin
                // Fetch is forced through once the data side has used up its burst.
                if (if_req_i && (r_streak == STREAK_MAX)) begin
                    w_next     = SB_BUS_IF;
                    w_grant_if = 1'b1;
                end else if (ex_req_i) begin
                    w_next     = SB_BUS_EX;
                    w_grant_ex = 1'b1;
                end else if (if_req_i) begin
                    w_next     = SB_BUS_IF;
                    w_grant_if = 1'b1;
                end
            end
            SB_BUS_EX: begin
                w_ex_ack = sb_ack_i;
                w_ex_err = w_expire;
                if (sb_ack_i || w_expire) begin
                    w_next = SB_IDLE;
                end
            end
            SB_BUS_IF: begin
                w_if_ack = sb_ack_i;
                w_if_err = w_expire;
                if (sb_ack_i || w_expire) begin
                    w_next = SB_IDLE;
                end
            end
            default: begin
                w_next = SB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= 4'd0;
        end else if (!if_req_i || w_grant_if) begin
            r_streak <= 4'd0;
        end else if (w_grant_ex && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // Bus-side attributes are captured once at grant and held for the whole transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_we       <= 1'b0;
            r_sb_addr     <= 32'd0;
            r_sb_wdata    <= 32'd0;
            r_sb_byte_sel <= '0;
        end else if (w_grant_ex) begin
            r_sb_we       <= ex_we_i;
            r_sb_addr     <= ex_addr_i;
            r_sb_wdata    <= ex_wdata_i;
            r_sb_byte_sel <= ex_byte_sel_i;
        end else if (w_grant_if) begin
            r_sb_we       <= 1'b0;
            r_sb_addr     <= if_addr_i;
            r_sb_wdata    <= 32'd0;
            r_sb_byte_sel <= SB_WORD;
        end
    end

    sb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (w_grant_ex | w_grant_if),
        .ack    (sb_ack_i),
        .expire (w_expire)
    );

    assign sb_req_o      = (r_state != SB_IDLE);
    assign sb_we_o       = r_sb_we;
    assign sb_addr_o     = r_sb_addr;
    assign sb_wdata_o    = r_sb_wdata;
    assign sb_byte_sel_o = r_sb_byte_sel;

    assign ex_ack_o   = w_ex_ack;
    assign ex_err_o   = w_ex_err;
    assign if_ack_o   = w_if_ack;
    assign if_err_o   = w_if_err;
    assign ex_rdata_o = (r_state == SB_BUS_EX) ? sb_rdata_i : 32'd0;
    assign if_rdata_o = (r_state == SB_BUS_IF) ? sb_rdata_i : 32'd0;

    assign hold_o = (ex_req_i && !w_ex_ack && !w_ex_err && !rst) ? HOLD : NO_HOLD;

endmodule

// File: doc/sb_arbiter.md
Name: sb_arbiter

Overview:
- Shares the single system-bus (sb) port between two masters: the execute stage (load/store) and instruction fetch.
- Sequences each transfer as request, grant, wait-for-slave-ack, release.
- Gives data accesses priority, with a starvation guard for fetch and a per-transfer timeout.
- Drives hold_o to pc while an execute-stage access is outstanding.

Parameters:
- MAX_EX_BURST, 4: max consecutive ex grants while if_req_i is pending before fetch is forced a grant; range 1..15.
- TIMEOUT, 16: cycles in a bus state without sb_ack_i before abort; 0 disables; range 0..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ex_req_i  in  1  execute-stage request; held until ex_ack_o or ex_err_o
- ex_we_i  in  1  1=write, 0=read
- ex_addr_i  in  32  byte address
- ex_wdata_i  in  32  store data
- ex_byte_sel_i  in  `BYTE_SEL  access size
- ex_ack_o  out  1  transfer complete, 1-cycle pulse
- ex_err_o  out  1  transfer timed out, 1-cycle pulse
- ex_rdata_o  out  32  load data, valid with ex_ack_o
- if_req_i  in  1  fetch request; held until if_ack_o or if_err_o
- if_addr_i  in  32  fetch address
- if_ack_o  out  1  fetch complete, 1-cycle pulse
- if_err_o  out  1  fetch timed out, 1-cycle pulse
- if_rdata_o  out  32  instruction word, valid with if_ack_o
- sb_req_o  out  1  bus request to slave
- sb_we_o  out  1  write enable to slave
- sb_addr_o  out  32  address to slave
- sb_wdata_o  out  32  write data to slave
- sb_byte_sel_o  out  `BYTE_SEL  size to slave
- sb_ack_i  in  1  slave done; may be asserted in the first cycle sb_req_o is high
- sb_rdata_i  in  32  slave read data, valid with sb_ack_i
- hold_o  out  1  stall request to pc

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high:
  - state=IDLE; both counters=0.
  - sb_req_o, sb_we_o, sb_addr_o, sb_wdata_o, sb_byte_sel_o = 0.
  - All ack/err outputs = 0; rdata outputs = 0.
  - An in-flight transfer is dropped with no ack or err.
- States:
  - IDLE: no owner.
  - BUS_EX: ex owns the bus.
  - BUS_IF: fetch owns the bus.
- Arbitration (IDLE only, evaluated each cycle):
  - If if_req_i=1 and streak==MAX_EX_BURST, go to BUS_IF.
  - Else if ex_req_i=1, go to BUS_EX.
  - Else if if_req_i=1, go to BUS_IF.
  - Else stay in IDLE.
- Grant action (on the IDLE to BUS_x edge):
  - Register the owner's we/addr/wdata/byte_sel into the sb_* output registers.
  - For fetch: sb_we_o=0, sb_byte_sel_o=word, sb_wdata_o=0.
  - sb_req_o=1 from the next cycle. sb_* outputs are stable for the whole bus state.
- Completion (BUS_x with sb_ack_i=1):
  - Owner ack_o=1 combinationally in the same cycle.
  - Owner rdata_o = sb_rdata_i combinationally.
  - Next state is IDLE; sb_req_o=0 on the next cycle.
  - Requesters must drop req in the cycle after ack. The mandatory IDLE cycle guarantees a completed request is never re-granted.
- Latency: ex_req_i rises in cycle N while IDLE; sb_req_o=1 at N+1; earliest ex_ack_o at N+1. Back-to-back transfers from one master: 3 cycles each minimum.
- Streak counter (4-bit):
  - Increments on each BUS_EX grant made while if_req_i=1, saturating at MAX_EX_BURST.
  - Clears on each BUS_IF grant, and in any cycle with if_req_i=0.
- Timeout counter (8-bit):
  - Clears on entering a bus state; increments each bus-state cycle with sb_ack_i=0.
  - When it reaches TIMEOUT (TIMEOUT≠0): owner err_o=1 for that cycle, no ack, next state IDLE, sb_req_o drops.
  - sb_ack_i in the same cycle as the limit: ack wins, no err.
- hold_o = ex_req_i & ~ex_ack_o & ~ex_err_o, combinational. It is low during reset.
- Outputs to the non-owner: ack/err = 0, rdata = 0.
- Requests arriving while in a bus state wait; no preemption.
- sb_ack_i while IDLE is ignored.

Decomposition:
- Add to defines.v:
  - `SB_STATE width (2) and encodings `SB_IDLE=0, `SB_BUS_EX=1, `SB_BUS_IF=2.
  - `SB_WORD byte_sel code.
  - `HOLD / `NO_HOLD levels.
- One sub-module: sb_watchdog.
  - Contains the timeout counter only.
  - Inputs: clk, rst, start, ack.
  - Output: expire.
- Arbitration FSM, streak counter and muxing stay in sb_arbiter.

Test Plan:
- ex read to 0x0000_0100, slave acks after 2 wait cycles with 0xDEAD_BEEF -> sb_req_o high 3 cycles; ex_ack_o pulses once with ex_rdata_o=0xDEAD_BEEF; hold_o high from request cycle through the cycle before the ack cycle.
- ex write and if fetch raised in the same IDLE cycle, zero-wait slave -> ex granted first (sb_we_o=1, sb_addr_o=ex_addr_i); IF granted after one IDLE cycle; if_ack_o pulses with the instruction data.
- MAX_EX_BURST=4, if_req_i held high, ex_req_i re-asserted continuously -> exactly 4 ex grants, then one IF grant, then ex resumes.
- TIMEOUT=16, slave never acks an IF request -> if_err_o pulses on the 16th bus cycle, no if_ack_o; sb_req_o low the next cycle; FSM back to IDLE.
- TIMEOUT=16, sb_ack_i arrives on exactly the 16th cycle -> ack only, err stays 0.
- rst asserted mid-BUS_EX, off clock edge -> sb_req_o and hold_o go to 0 immediately; no ack/err; after release, a fresh ex request completes normally.
